itof_pipe: RTL and testbench
============================

ITOF_PIPE -- requirements
Module: itof_pipe

Interface
REQ-001 Parameter ROUND, default 1: 1 = round-to-nearest, ties away from zero; 0 = truncate toward zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_data holds an operand.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  32  two's-complement signed integer.
REQ-007 out_valid  output  1  out_data holds a result.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.

Function
REQ-010 Transfer occurs on a cycle with valid=1 and ready=1 at that port; no other cycle transfers.
REQ-011 Fixed 3-stage pipeline; a result accepted at cycle N appears with out_valid=1 at cycle N+3 when no stall occurs.
REQ-012 Global advance enable adv = !out_valid | out_ready; in_ready = adv, combinational, no dependence on in_valid.
REQ-013 When adv=0 every stage register, including out_data and out_valid, holds its value.
REQ-014 Throughput one result per cycle while out_ready=1; no bubbles inserted by the block.
REQ-015 Results leave in acceptance order; no result is dropped or duplicated across stalls.
REQ-016 Stage 1: sign s = in_data[31]; magnitude mag = s ? -in_data : in_data as 32-bit unsigned (0x80000000 gives 2^31).
REQ-017 Stage 2: lz = leading-zero count of mag (0..31, 32 when mag=0); norm = mag << lz.
REQ-018 Stage 3: exp = 158 - lz; frac = norm[30:8]; guard = norm[7].
REQ-019 ROUND=1 and guard=1: frac+1; on carry out of frac, frac=0 and exp+1.
REQ-020 ROUND=0: guard ignored, result truncated.
REQ-021 mag=0 produces 0x00000000 (positive zero) regardless of ROUND.
REQ-022 Output never denormal, infinite or NaN; maximum exp is 158.
REQ-023 Bubble stages (valid=0) carry no obligation on data fields; out_data is don't-care while out_valid=0.

Reset
REQ-024 rst=1 at a rising edge clears all stage valid bits and out_valid to 0 and out_data to 0x00000000.
REQ-025 rst asserted mid-operation discards all in-flight operands; none emerge after reset.
REQ-026 in_ready during rst follows REQ-012 (reads 1); any transfer on a rst cycle is discarded.

Structure
REQ-027 Shared package fpu_pkg holds float field widths (1/8/23), exponent bias 127, and a packed float32 struct typedef.
REQ-028 Leading-zero count is a sub-module lzc32 (32-bit input, 6-bit count output, combinational), instantiated in stage 2.
REQ-029 No other sub-modules; no multipliers, no dividers.

Verification
REQ-030 Back-to-back, out_ready=1: 0, 1, -1, 3 -> 0x00000000, 0x3F800000, 0xBF800000, 0x40400000 on consecutive cycles 3 cycles later.
REQ-031 Extremes: 0x7FFFFFFF -> 0x4F000000 (rounding carry); 0x80000000 -> 0xCF000000.
REQ-032 Tie: 16777217 -> 0x4B800001 with ROUND=1, 0x4B800000 with ROUND=0; 16777219 -> 0x4B800002 with ROUND=1.
REQ-033 Stall: stream 10 operands, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 and out_data stable throughout; all 10 results delivered in order, no loss.
REQ-034 Reset mid-flight: accept 3 operands, assert rst one cycle -> out_valid=0 next cycle, out_data=0, none of the 3 results ever appear.
REQ-035 Random 10^6 operands with random out_ready vs. reference model of REQ-016..022 -> zero mismatches.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision float field definitions used by the integer-to-float pipeline.
package fpu_pkg;

    localparam int DATA_W   = 32;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    // Exponent of a value whose leading one sits at bit 31 of the normalised magnitude.
    localparam logic [EXP_W-1:0] EXP_TOP = 8'(EXP_BIAS + DATA_W - 1);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter for a 32-bit word; reports 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] din,
    output logic [5:0]  cnt
);

    always_comb begin
        cnt = 6'd32;
        // Later iterations overwrite earlier ones, so the highest set bit wins.
        for (int i = 0; i < 32; i++) begin
            if (din[i]) begin
                cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed 32-bit integer to IEEE-754 single converter with a single
// global stall (adv) shared by every stage.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic RND_EN = (ROUND != 0);

    logic adv;

    logic               vld_p1_q, vld_p1_d;
    logic               sign_p1_q, sign_p1_d;
    logic [DATA_W-1:0]  mag_p1_q, mag_p1_d;
    logic [5:0]         lz_p1;
    logic [DATA_W-1:0]  norm_p1;

    logic               vld_p2_q, vld_p2_d;
    logic               sign_p2_q, sign_p2_d;
    logic [5:0]         lz_p2_q, lz_p2_d;
    logic [24:0]        norm_p2_q, norm_p2_d;

    logic               out_valid_q, out_valid_d;
    float32_t           out_data_q, out_data_d;

    logic signed [DATA_W-1:0] in_sdata;
    logic signed [DATA_W-1:0] in_neg;

    // norm holds {leading one, 23 fraction bits, guard}; returns {carry, frac}.
    function automatic logic [FRAC_W:0] round_frac(input logic [24:0] norm, input logic rnd);
        round_frac = {1'b0, norm[23:1]} + {{FRAC_W{1'b0}}, rnd & norm[0]};
    endfunction

    function automatic float32_t pack_float(input logic sign, input logic [5:0] lz,
                                            input logic [24:0] norm, input logic rnd);
        logic [FRAC_W:0] r;
        pack_float = '0;
        r = round_frac(norm, rnd);
        if (norm[24]) begin
            pack_float.sign = sign;
            pack_float.exp  = EXP_TOP - {2'b00, lz} + {{(EXP_W-1){1'b0}}, r[FRAC_W]};
            pack_float.frac = r[FRAC_W-1:0];
        end
    endfunction

    assign adv       = !out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign in_sdata = in_data;
    assign in_neg   = -in_sdata;

    lzc32 u_lzc (
        .din (mag_p1_q),
        .cnt (lz_p1)
    );

    assign norm_p1 = mag_p1_q << lz_p1;

    always_comb begin
        vld_p1_d    = vld_p1_q;
        sign_p1_d   = sign_p1_q;
        mag_p1_d    = mag_p1_q;
        vld_p2_d    = vld_p2_q;
        sign_p2_d   = sign_p2_q;
        lz_p2_d     = lz_p2_q;
        norm_p2_d   = norm_p2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            // stage 1: sign and magnitude (0x80000000 maps to 2^31)
            vld_p1_d    = in_valid;
            sign_p1_d   = in_sdata[DATA_W-1];
            mag_p1_d    = in_sdata[DATA_W-1] ? unsigned'(in_neg) : unsigned'(in_sdata);
            // stage 2: normalise, keeping only the leading one, fraction and guard bit
            vld_p2_d    = vld_p1_q;
            sign_p2_d   = sign_p1_q;
            lz_p2_d     = lz_p1;
            norm_p2_d   = 25'(norm_p1 >> 7);
            // stage 3: exponent, rounding and packing
            out_valid_d = vld_p2_q;
            out_data_d  = pack_float(sign_p2_q, lz_p2_q, norm_p2_q, RND_EN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_p1_q <= sign_p1_d;
        mag_p1_q  <= mag_p1_d;
        sign_p2_q <= sign_p2_d;
        lz_p2_q   <= lz_p2_d;
        norm_p2_q <= norm_p2_d;
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Randomised and directed bench for itof_pipe, running ROUND=1 and ROUND=0 side by side
// against an arithmetic reference model.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_ready1, out_valid1;
    logic [31:0] out_data1;
    logic        in_ready0, out_valid0;
    logic [31:0] out_data0;

    always #5 clk = ~clk;

    itof_pipe #(.ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
    );

    itof_pipe #(.ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: find the leading one arithmetically, shift to 24 significant bits,
    // optionally add the first discarded bit, renormalise on overflow.
    function automatic logic [31:0] ref_itof(input logic [31:0] x, input bit rnd);
        longint v, m, q;
        int     e, sh;
        bit     s;
        v = longint'($signed(x));
        if (v == 0) return 32'h0;
        s = (v < 0);
        m = s ? -v : v;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh = e - 23;
            q  = m >> sh;
            if (rnd && (((m >> (sh - 1)) & 1) != 0)) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e0;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs1[$];
    logic [31:0] obs0[$];
    int          cyc       = 0;
    int          stall_cnt = 0;
    bit          rst_prev  = 0;
    bit          hold      = 0;
    logic [31:0] held1, held0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
            chk("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
            chk("rst_out_data1", out_data1, 32'd0);
            chk("rst_out_data0", out_data0, 32'd0);
        end
        rst_prev = rst;
        chk("in_ready1", {31'd0, in_ready1}, {31'd0, (!out_valid1 || out_ready)});
        chk("in_ready0", {31'd0, in_ready0}, {31'd0, (!out_valid0 || out_ready)});
        if (hold) begin
            chk("stall_valid", {31'd0, out_valid1 & out_valid0}, 32'd1);
            chk("stall_data1", out_data1, held1);
            chk("stall_data0", out_data0, held0);
        end
        if (rst) begin
            exp_q.delete();
            hold = 0;
        end else begin
            if (out_valid1 && out_ready) begin
                obs1.push_back(out_data1);
                obs0.push_back(out_data0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_r1", out_data1, e.e1);
                    chk("result_r0", out_data0, e.e0);
                    chk("valid_r0", {31'd0, out_valid0}, 32'd1);
                    if (e.stl == stall_cnt) chk("latency", cyc, e.cyc + 3);
                end
            end
            if (in_valid && in_ready1) begin
                e.e1  = ref_itof(in_data, 1'b1);
                e.e0  = ref_itof(in_data, 1'b0);
                e.cyc = cyc;
                e.stl = stall_cnt;
                exp_q.push_back(e);
            end
            if (out_valid1 && !out_ready) begin
                hold  = 1;
                held1 = out_data1;
                held0 = out_data0;
                stall_cnt++;
            end else begin
                hold = 0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
        step();
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        int          k;
        k = $urandom_range(0, 5);
        case (k)
            0: r = $urandom_range(0, 20) - 10;
            1: r = 32'h1000000 + $urandom_range(0, 7);
            2: r = $urandom_range(0, 1) ? 32'h7FFFFFFF - $urandom_range(0, 300)
                                        : 32'h80000000 + $urandom_range(0, 300);
            3: r = $urandom >> $urandom_range(0, 31);
            default: r = $urandom;
        endcase
        return r;
    endfunction

    logic [31:0] dir_in[8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'd3, 32'h7FFFFFFF,
                               32'h80000000, 32'd16777217, 32'd16777219};
    logic [31:0] lit1[8]   = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h40400000,
                               32'h4F000000, 32'hCF000000, 32'h4B800001, 32'h4B800002};
    logic [31:0] lit0[8]   = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h40400000,
                               32'h4EFFFFFF, 32'hCF000000, 32'h4B800000, 32'h4B800001};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;

        for (int i = 0; i < 8; i++) begin
            chk("model_pin_r1", ref_itof(dir_in[i], 1'b1), lit1[i]);
            chk("model_pin_r0", ref_itof(dir_in[i], 1'b0), lit0[i]);
        end

        step();
        step();
        rst = 1'b0;
        obs1.delete();
        obs0.delete();

        // Back-to-back directed operands with known results.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = dir_in[i];
            step();
        end
        drain("drain_directed");
        chk("directed_count", obs1.size(), 8);
        for (int i = 0; i < 8 && i < obs1.size(); i++) begin
            chk("directed_r1", obs1[i], lit1[i]);
            chk("directed_r0", obs0[i], lit0[i]);
        end

        // Ten operands with a five-cycle consumer stall in the middle.
        begin
            int k, t;
            bit acc;
            k = 0;
            t = 0;
            while (k < 10 && t < 100) begin
                in_valid  = 1'b1;
                in_data   = 32'd1000 * k + 7;
                out_ready = !(t >= 6 && t < 11);
                acc       = in_ready1;
                step();
                if (acc) k++;
                t++;
            end
            chk("stall_stream_accepted", k, 10);
        end
        drain("drain_stall");

        // Reset while three operands are in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd500 + i;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 20000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rand_operand();
            rst       = ($urandom_range(0, 2999) == 0);
            step();
        end
        rst = 1'b0;
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
